// File: rtl/gal_array_prog.sv
// GAL-style programmable logic array: fuse map streamed in bytewise, then OLMCs evaluate.
// Latency: registered OLMCs 1 clk, combinational OLMCs 0 clk; programming 1 clk per byte.
// Backpressure: fuse_ready high only while unprogrammed/loading. Optional macro CHECKSUM_EN.
module gal_array_prog #(
  parameter int NUM_IN   = 8,
  parameter int NUM_OLMC = 8,
  parameter int NUM_PT   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN-1:0]   in,
  input  logic                oe_n,
  inout  wire  [NUM_OLMC-1:0] io,
  input  logic                prog_start,
  input  logic [7:0]          fuse_data,
  input  logic                fuse_valid,
  output logic                fuse_ready,
  output logic                prog_done,
  output logic                prog_err
);

  localparam int C      = NUM_IN + NUM_OLMC;
  localparam int TW     = 2 * C + 1;
  localparam int B      = NUM_PT * TW + 2;
  localparam int FUSES  = NUM_OLMC * B;
  localparam int NBYTES = (FUSES + 7) / 8;
  localparam int AW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int CW     = $clog2(NBYTES + 2) + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);
  localparam logic [CW-1:0] CNT_NB   = CW'(NBYTES);
`ifdef CHECKSUM_EN
  localparam logic [CW-1:0] CNT_CHK  = CW'(NBYTES + 1);
`endif

  typedef enum logic [1:0] {S_UNPROG, S_LOADING, S_RUN, S_ERROR} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [7:0]          fmem [NBYTES];
  logic [FUSES-1:0]    fuses;
`ifdef CHECKSUM_EN
  logic [15:0]         csum;
  logic [7:0]          csum_lo;
`endif

  logic                run;
  logic [NUM_OLMC-1:0] mreg;
  logic [NUM_OLMC-1:0] olmc_out;
  logic [NUM_OLMC-1:0] oe_term;
  logic [NUM_OLMC-1:0] io_oe;
  logic [NUM_OLMC-1:0] io_val;

  // Decoded fuse fields: need1 bit j set means the term requires column j = 1
  logic [C-1:0]        need1 [NUM_OLMC][NUM_PT];
  logic [C-1:0]        need0 [NUM_OLMC][NUM_PT];
  logic [NUM_PT-1:0]   ptd   [NUM_OLMC];
  logic [NUM_OLMC-1:0] xr;
  logic [NUM_OLMC-1:0] ac1;

  for (genvar i = 0; i < FUSES; i++) begin : g_fuse
    assign fuses[i] = fmem[i / 8][i % 8];
  end

  for (genvar k = 0; k < NUM_OLMC; k++) begin : g_olmc
    assign xr[k]  = fuses[k * B + NUM_PT * TW];
    assign ac1[k] = fuses[k * B + NUM_PT * TW + 1];
    for (genvar t = 0; t < NUM_PT; t++) begin : g_pt
      assign ptd[k][t] = fuses[k * B + t * TW + 2 * C];
      for (genvar j = 0; j < C; j++) begin : g_col
        assign need1[k][t][j] = ~fuses[k * B + t * TW + 2 * j];
        assign need0[k][t][j] = ~fuses[k * B + t * TW + 2 * j + 1];
      end
    end
  end

  assign run = (state == S_RUN);

  // Programming FSM: accepts fuse bytes, tracks the byte count and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_UNPROG;
      cnt        <= '0;
      fuse_ready <= 1'b1;
      prog_done  <= 1'b0;
      prog_err   <= 1'b0;
      for (int i = 0; i < NBYTES; i++) fmem[i] <= '0;
`ifdef CHECKSUM_EN
      csum       <= '0;
      csum_lo    <= '0;
`endif
    end else if (prog_start) begin
      // restart wins over any byte offered in the same cycle
      state      <= S_UNPROG;
      cnt        <= '0;
      fuse_ready <= 1'b1;
      prog_done  <= 1'b0;
      prog_err   <= 1'b0;
      for (int i = 0; i < NBYTES; i++) fmem[i] <= '0;
`ifdef CHECKSUM_EN
      csum       <= '0;
      csum_lo    <= '0;
`endif
    end else if (fuse_valid && fuse_ready) begin
      cnt <= cnt + 1'b1;
      if (cnt < CNT_NB) begin
        fmem[cnt[AW-1:0]] <= fuse_data;
`ifdef CHECKSUM_EN
        csum <= csum + {8'h00, fuse_data};
`endif
      end
`ifdef CHECKSUM_EN
      if (cnt == CNT_NB) csum_lo <= fuse_data;
      if (cnt == CNT_CHK) begin
        fuse_ready <= 1'b0;
        if ({fuse_data, csum_lo} == csum) begin
          state     <= S_RUN;
          prog_done <= 1'b1;
        end else begin
          state    <= S_ERROR;
          prog_err <= 1'b1;
        end
      end else begin
        state <= S_LOADING;
      end
`else
      if (cnt == CNT_LAST) begin
        state      <= S_RUN;
        fuse_ready <= 1'b0;
        prog_done  <= 1'b1;
      end else begin
        state <= S_LOADING;
      end
`endif
    end
  end

  // Array evaluation. Feedback through comb OLMCs is resolved by NUM_OLMC+1 unrolled
  // passes, enough for any acyclic chain; a genuine loop simply stops changing here.
  always_comb begin
    logic [NUM_OLMC-1:0] fb_v;
    logic [NUM_OLMC-1:0] out_v;
    logic [NUM_OLMC-1:0] t0_v;
    logic [C-1:0]        cols;
    logic                sum_pt;
    logic                hit;
    fb_v   = '0;
    out_v  = '0;
    t0_v   = '0;
    cols   = '0;
    sum_pt = 1'b0;
    hit    = 1'b0;
    for (int p = 0; p <= NUM_OLMC; p++) begin
      cols = {fb_v, in};
      for (int k = 0; k < NUM_OLMC; k++) begin
        sum_pt = 1'b0;
        for (int t = 0; t < NUM_PT; t++) begin
          hit = ptd[k][t] & ~|((need1[k][t] & ~cols) | (need0[k][t] & cols));
          if (t == 0) t0_v[k] = hit;
          // in comb mode term 0 is the output-enable term, not part of the sum
          if (t != 0 || !ac1[k]) sum_pt = sum_pt | hit;
        end
        out_v[k] = sum_pt ^ xr[k];
      end
      for (int k = 0; k < NUM_OLMC; k++) begin
        fb_v[k] = run & (ac1[k] ? out_v[k] : ~mreg[k]);
      end
    end
    olmc_out = out_v;
    oe_term  = t0_v;
  end

  // Macrocell registers: clock the OLMC sum in RUN, held at 0 otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreg <= '0;
    end else if (prog_start || !run) begin
      mreg <= '0;
    end else begin
      mreg <= olmc_out;
    end
  end

  for (genvar k = 0; k < NUM_OLMC; k++) begin : g_io
    assign io_oe[k]  = run & (ac1[k] ? oe_term[k] : ~oe_n);
    assign io_val[k] = ac1[k] ? ~olmc_out[k] : ~mreg[k];
    assign io[k]     = io_oe[k] ? io_val[k] : 1'bz;
  end

endmodule

// File: tb/tb_gal_array_prog.sv
// Bench for gal_array_prog: streams fuse maps and compares pins against a fuse-level model.
// Model iterates feedback to a fixed point and tracks macrocell registers per clock.
// Covers reset, reg/comb modes, feedback, random maps, mid-load stall/restart/reset, checksum.
`timescale 1ns/1ps
module tb_gal_array_prog;
  localparam int NI = 8;
  localparam int NO = 8;
  localparam int NP = 8;
  localparam int C = NI + NO;
  localparam int TW = 2 * C + 1;
  localparam int B = NP * TW + 2;
  localparam int FUSES = NO * B;
  localparam int NBYTES = (FUSES + 7) / 8;
`ifdef CHECKSUM_EN
  localparam int NSTREAM = NBYTES + 2;
`else
  localparam int NSTREAM = NBYTES;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] in_w = '0;
  logic          oe_n = 1'b1;
  wire  [NO-1:0] io;
  logic          prog_start = 1'b0;
  logic [7:0]    fuse_data = '0;
  logic          fuse_valid = 1'b0;
  logic          fuse_ready;
  logic          prog_done;
  logic          prog_err;

  int checks = 0;
  int fails = 0;

  bit [FUSES-1:0] tb_fz;
  bit [FUSES-1:0] mfuse;
  bit [NO-1:0]    mreg_m;
  bit             mrun;
  logic [7:0]     stream [$];

  gal_array_prog #(.NUM_IN(NI), .NUM_OLMC(NO), .NUM_PT(NP)) dut (
    .clk(clk), .rst_n(rst_n), .in(in_w), .oe_n(oe_n), .io(io),
    .prog_start(prog_start), .fuse_data(fuse_data), .fuse_valid(fuse_valid),
    .fuse_ready(fuse_ready), .prog_done(prog_done), .prog_err(prog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- fuse map construction ----------------
  function automatic void set_term(int k, int t, logic [C-1:0] n1, logic [C-1:0] n0, bit p);
    int base;
    base = k * B + t * TW;
    for (int j = 0; j < C; j++) begin
      tb_fz[base + 2 * j]     = !n1[j];
      tb_fz[base + 2 * j + 1] = !n0[j];
    end
    tb_fz[base + 2 * C] = p;
  endfunction

  function automatic void set_mode(int k, bit x, bit a);
    tb_fz[k * B + NP * TW]     = x;
    tb_fz[k * B + NP * TW + 1] = a;
  endfunction

  function automatic void map_reg();
    tb_fz = '0;
    set_term(0, 0, C'(1), '0, 1'b1);
  endfunction

  // random map; comb OLMCs only use comb feedback from lower-numbered comb OLMCs
  function automatic void rand_map();
    bit [NO-1:0] ac;
    bit n1, n0;
    int r, base;
    tb_fz = '0;
    for (int k = 0; k < NO; k++) ac[k] = 1'($urandom_range(0, 1));
    for (int k = 0; k < NO; k++) begin
      for (int t = 0; t < NP; t++) begin
        base = k * B + t * TW;
        tb_fz[base + 2 * C] = ($urandom_range(0, 3) != 0);
        for (int j = 0; j < C; j++) begin
          r = int'($urandom_range(0, 9));
          n1 = (r == 0);
          n0 = (r == 1);
          if (j >= NI && ac[k] && ac[j - NI] && (j - NI) >= k) begin
            n1 = 1'b0;
            n0 = 1'b0;
          end
          tb_fz[base + 2 * j]     = !n1;
          tb_fz[base + 2 * j + 1] = !n0;
        end
      end
      set_mode(k, 1'($urandom_range(0, 1)), ac[k]);
    end
  endfunction

  function automatic void build_stream(int delta);
    logic [7:0]  b;
    logic [15:0] sum;
    stream.delete();
    sum = '0;
    for (int n = 0; n < NBYTES; n++) begin
      b = '0;
      for (int i = 0; i < 8; i++) if (8 * n + i < FUSES) b[i] = tb_fz[8 * n + i];
      stream.push_back(b);
      sum = sum + {8'h00, b};
    end
    sum = sum + 16'(delta);
    stream.push_back(sum[7:0]);
    stream.push_back(sum[15:8]);
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic bit m_term(int k, int t, logic [C-1:0] cols);
    int base;
    base = k * B + t * TW;
    if (!mfuse[base + 2 * C]) return 1'b0;
    for (int j = 0; j < C; j++) begin
      if (!mfuse[base + 2 * j] && !cols[j]) return 1'b0;
      if (!mfuse[base + 2 * j + 1] && cols[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_io(output logic [NO-1:0] en, output logic [NO-1:0] val,
                                   output logic [NO-1:0] nxt);
    logic [NO-1:0] fb, nfb, outv, t0v;
    logic [C-1:0]  cols;
    bit            anyt, a;
    en = '0; val = '0; nxt = '0; outv = '0; t0v = '0; nfb = '0;
    if (!mrun) return;
    fb = ~mreg_m;
    for (int it = 0; it < 4 * NO + 4; it++) begin
      cols = {fb, in_w};
      for (int k = 0; k < NO; k++) begin
        a = mfuse[k * B + NP * TW + 1];
        anyt = 1'b0;
        for (int t = 0; t < NP; t++) if (t > 0 || !a) anyt |= m_term(k, t, cols);
        outv[k] = anyt ^ mfuse[k * B + NP * TW];
        t0v[k]  = m_term(k, 0, cols);
        nfb[k]  = a ? outv[k] : ~mreg_m[k];
      end
      if (nfb == fb) break;
      fb = nfb;
    end
    for (int k = 0; k < NO; k++) begin
      a = mfuse[k * B + NP * TW + 1];
      en[k]  = a ? t0v[k] : !oe_n;
      val[k] = a ? ~outv[k] : ~mreg_m[k];
    end
    nxt = outv;
  endfunction

  task automatic step();
    logic [NO-1:0] e, v, n;
    model_io(e, v, n);
    @(posedge clk); #1;
    mreg_m = mrun ? n : '0;
  endtask

  task automatic set_run();
    mfuse = tb_fz;
    mrun = 1'b1;
    mreg_m = '0;
  endtask

  task automatic restart();
    @(negedge clk);
    prog_start = 1'b1;
    @(posedge clk); #1;
    prog_start = 1'b0;
    mrun = 1'b0;
    mreg_m = '0;
  endtask

  // offers stream bytes; early flags prog_done seen before the last byte was accepted
  task automatic send_bytes(input int count, input int stall_at, output int accepted,
                            output bit early);
    int guard;
    bit acc, stalled;
    accepted = 0; early = 1'b0; guard = 0; stalled = 1'b0;
    while (accepted < count && guard < count + 64) begin
      if (accepted == stall_at && !stalled) begin
        fuse_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        stalled = 1'b1;
      end
      fuse_valid = 1'b1;
      fuse_data = stream[accepted];
      @(negedge clk);
      if (prog_done) early = 1'b1;
      acc = fuse_ready;
      @(posedge clk); #1;
      if (acc) accepted++;
      guard++;
    end
    fuse_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (fuse_ready !== 1'b1) begin fails++; $display("FAIL reset_fuse_ready: got %b want 1", fuse_ready); end
    checks++; if (prog_done !== 1'b0) begin fails++; $display("FAIL reset_prog_done: got %b want 0", prog_done); end
    checks++; if (prog_err !== 1'b0) begin fails++; $display("FAIL reset_prog_err: got %b want 0", prog_err); end
    checks++; if (dut.io_oe !== '0) begin fails++; $display("FAIL reset_io_z: drive %b want 0", dut.io_oe); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    mrun = 1'b0; mreg_m = '0;
  endtask

  task automatic test_default_load();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    tb_fz = '0;
    build_stream(0);
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (acc != NSTREAM || early) begin fails++; $display("FAIL default_count: accepted %0d early %b want %0d 0", acc, early, NSTREAM); end
    checks++; if (prog_done !== 1'b1) begin fails++; $display("FAIL default_done: got %b want 1", prog_done); end
    checks++; if (fuse_ready !== 1'b0) begin fails++; $display("FAIL run_fuse_ready: got %b want 0", fuse_ready); end
    set_run();
    oe_n = 1'b0;
    step();
    checks++; if (io !== {NO{1'b1}}) begin fails++; $display("FAIL default_io: got %h want ff", io); end
    fuse_valid = 1'b1; fuse_data = 8'h5A;
    step(); step(); step();
    fuse_valid = 1'b0;
    model_io(e, v, n);
    checks++; if (prog_done !== 1'b1 || dut.io_oe !== e || ((io ^ v) & e) !== '0) begin
      fails++; $display("FAIL run_ignores_valid: done %b io %h want 1 %h", prog_done, io, v); end
  endtask

  task automatic test_registered();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    restart();
    map_reg();
    build_stream(0);
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (prog_done !== 1'b1 || early) begin fails++; $display("FAIL reg_load: done %b early %b", prog_done, early); end
    set_run();
    oe_n = 1'b0;
    in_w = '0; in_w[0] = 1'b1;
    step();
    model_io(e, v, n);
    checks++; if (io[0] !== 1'b0 || dut.io_oe !== e || ((io ^ v) & e) !== '0) begin
      fails++; $display("FAIL reg_in1: io %h want %h", io, v); end
    in_w[0] = 1'b0;
    step();
    model_io(e, v, n);
    checks++; if (io[0] !== 1'b1 || ((io ^ v) & e) !== '0) begin fails++; $display("FAIL reg_in0: io %h want %h", io, v); end
    oe_n = 1'b1; #1;
    checks++; if (dut.io_oe[0] !== 1'b0) begin fails++; $display("FAIL reg_oe_n: drive %b want 0", dut.io_oe[0]); end
  endtask

  task automatic test_comb();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    restart();
    tb_fz = '0;
    set_term(1, 0, '0, '0, 1'b1);
    set_term(1, 1, C'(6), '0, 1'b1);
    set_mode(1, 1'b1, 1'b1);
    build_stream(0);
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (prog_done !== 1'b1 || early) begin fails++; $display("FAIL comb_load: done %b early %b", prog_done, early); end
    set_run();
    oe_n = 1'b1;
    in_w = NI'(6); #1;
    model_io(e, v, n);
    checks++; if (dut.io_oe[1] !== 1'b1 || io[1] !== 1'b1 || ((io ^ v) & e) !== '0) begin
      fails++; $display("FAIL comb_and_true: drive %b io %b want 1 1", dut.io_oe[1], io[1]); end
    in_w[2] = 1'b0; #1;
    model_io(e, v, n);
    checks++; if (io[1] !== 1'b0 || ((io ^ v) & e) !== '0) begin fails++; $display("FAIL comb_and_false: io %b want 0", io[1]); end
  endtask

  task automatic test_feedback_toggle();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    restart();
    tb_fz = '0;
    set_term(2, 0, C'(1) << (NI + 2), '0, 1'b1);
    build_stream(0);
    send_bytes(NSTREAM, -1, acc, early);
    set_run();
    oe_n = 1'b0; #1;
    checks++; if (io[2] !== 1'b1) begin fails++; $display("FAIL toggle_start: io2 %b want 1", io[2]); end
    for (int i = 1; i <= 6; i++) begin
      step();
      model_io(e, v, n);
      checks++; if (io[2] !== ((i % 2) == 0) || ((io ^ v) & e) !== '0) begin
        fails++; $display("FAIL toggle_%0d: io %h want %h", i, io, v); end
    end
  endtask

  task automatic test_random();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    for (int m = 0; m < 3; m++) begin
      restart();
      rand_map();
      build_stream(0);
      send_bytes(NSTREAM, -1, acc, early);
      checks++; if (prog_done !== 1'b1 || early || acc != NSTREAM) begin
        fails++; $display("FAIL rand_load_%0d: done %b early %b acc %0d", m, prog_done, early, acc); end
      set_run();
      for (int c = 0; c < 25; c++) begin
        in_w = NI'($urandom);
        oe_n = 1'($urandom_range(0, 1));
        #1;
        model_io(e, v, n);
        checks++; if (dut.io_oe !== e || ((io ^ v) & e) !== '0) begin
          fails++; $display("FAIL rand_%0d_%0d: drive %b io %h want %b %h", m, c, dut.io_oe, io, e, v); end
        step();
      end
    end
  endtask

  task automatic test_midload();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    restart();
    rand_map();
    build_stream(0);
    send_bytes(NSTREAM, 100, acc, early);
    checks++; if (acc != NSTREAM || early || prog_done !== 1'b1) begin
      fails++; $display("FAIL stall_load: acc %0d early %b done %b want %0d 0 1", acc, early, prog_done, NSTREAM); end
    restart();
    send_bytes(150, -1, acc, early);
    fuse_valid = 1'b1; fuse_data = 8'hA5; prog_start = 1'b1;
    @(posedge clk); #1;
    prog_start = 1'b0; fuse_valid = 1'b0;
    checks++; if (prog_done !== 1'b0 || fuse_ready !== 1'b1) begin
      fails++; $display("FAIL restart_state: done %b ready %b want 0 1", prog_done, fuse_ready); end
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (acc != NSTREAM || early || prog_done !== 1'b1) begin
      fails++; $display("FAIL restart_reload: acc %0d early %b done %b", acc, early, prog_done); end
    set_run();
    for (int c = 0; c < 6; c++) begin
      in_w = NI'($urandom); oe_n = 1'b0; #1;
      model_io(e, v, n);
      checks++; if (dut.io_oe !== e || ((io ^ v) & e) !== '0) begin
        fails++; $display("FAIL restart_io_%0d: io %h want %h", c, io, v); end
      step();
    end
  endtask

  task automatic test_async_reset();
    int acc; bit early;
    logic [NO-1:0] e, v, n;
    restart();
    tb_fz = '0;
    build_stream(0);
    send_bytes(NSTREAM, -1, acc, early);
    set_run();
    oe_n = 1'b0;
    step();
    #2; rst_n = 1'b0; #1;
    checks++; if (prog_done !== 1'b0 || dut.io_oe !== '0 || fuse_ready !== 1'b1) begin
      fails++; $display("FAIL arst_run: done %b drive %b ready %b want 0 0 1", prog_done, dut.io_oe, fuse_ready); end
    mrun = 1'b0; mreg_m = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    map_reg();
    build_stream(0);
    send_bytes(150, -1, acc, early);
    #2; rst_n = 1'b0; #1;
    checks++; if (prog_done !== 1'b0 || fuse_ready !== 1'b1) begin
      fails++; $display("FAIL arst_load: done %b ready %b want 0 1", prog_done, fuse_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (acc != NSTREAM || early || prog_done !== 1'b1) begin
      fails++; $display("FAIL arst_reload: acc %0d early %b done %b", acc, early, prog_done); end
    set_run();
    in_w = '0; in_w[0] = 1'b1;
    step();
    model_io(e, v, n);
    checks++; if (io[0] !== 1'b0 || ((io ^ v) & e) !== '0) begin fails++; $display("FAIL arst_io: io %h want %h", io, v); end
  endtask

`ifdef CHECKSUM_EN
  task automatic test_checksum();
    int acc; bit early;
    restart();
    rand_map();
    build_stream(0);
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (prog_done !== 1'b1 || prog_err !== 1'b0 || early) begin
      fails++; $display("FAIL csum_good: done %b err %b want 1 0", prog_done, prog_err); end
    restart();
    build_stream(1);
    send_bytes(NSTREAM, -1, acc, early);
    checks++; if (prog_err !== 1'b1 || prog_done !== 1'b0 || fuse_ready !== 1'b0 || dut.io_oe !== '0) begin
      fails++; $display("FAIL csum_bad: err %b done %b ready %b drive %b", prog_err, prog_done, fuse_ready, dut.io_oe); end
    restart();
    checks++; if (prog_err !== 1'b0 || fuse_ready !== 1'b1) begin
      fails++; $display("FAIL csum_restart: err %b ready %b want 0 1", prog_err, fuse_ready); end
  endtask
`endif

  initial begin
    test_reset();
    test_default_load();
    test_registered();
    test_comb();
    test_feedback_toggle();
    test_random();
    test_midload();
    test_async_reset();
`ifdef CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
